// File: rtl/cam_cmd_sequencer.sv
// Command sequencer in front of the 32-entry CAM: queues read/write/search commands,
// issues one per cycle, and returns read/search results in order under credit control.
module cam_cmd_sequencer #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int CAM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [IDX_W-1:0]  cmd_index_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              cam_read_enable_o,
  output logic [IDX_W-1:0]  cam_read_index_o,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_read_valid_i,
  input  logic [DATA_W-1:0] cam_read_value_i,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_op_o,
  output logic              rsp_hit_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int RCW = RPW + 1;
  localparam int SW  = RPW + 4;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, HOLD = 2'b10} state_t;

  state_t              state_r;
  logic [1:0]          cmd_op_mem_r   [CMD_DEPTH];
  logic [IDX_W-1:0]    cmd_idx_mem_r  [CMD_DEPTH];
  logic [DATA_W-1:0]   cmd_data_mem_r [CMD_DEPTH];
  logic [CPW-1:0]      cmd_wr_ptr_r, cmd_rd_ptr_r;
  logic [CCW-1:0]      cmd_count_r;
  logic                rsp_op_mem_r   [RSP_DEPTH];
  logic                rsp_hit_mem_r  [RSP_DEPTH];
  logic [DATA_W-1:0]   rsp_data_mem_r [RSP_DEPTH];
  logic [RPW-1:0]      rsp_wr_ptr_r, rsp_rd_ptr_r;
  logic [RCW-1:0]      rsp_count_r;
  logic [CAM_LAT-1:0]  track_v_r, track_op_r;
  logic [2:0]          inflight_r;
  logic                cmd_ready_r, rsp_valid_r, busy_r;
  logic [7:0]          err_cnt_r;
  logic                rd_en_r, wr_en_r, sr_en_r;
  logic [IDX_W-1:0]    rd_idx_r, wr_idx_r;
  logic [DATA_W-1:0]   wr_data_r, sr_data_r;

  logic [1:0]          head_op_s;
  logic                needs_credit_s, credit_ok_s;
  logic                cmd_push_s, cmd_pop_s, issue_rs_s;
  logic                cap_s, cap_hit_s, rsp_pop_s;
  logic [DATA_W-1:0]   cap_data_s;
  logic [CCW-1:0]      cmd_count_next_s;
  logic [RCW-1:0]      rsp_count_next_s;
  logic [2:0]          inflight_next_s;

  // Handshakes, credit check and next-count arithmetic
  always_comb begin
    head_op_s      = cmd_op_mem_r[cmd_rd_ptr_r];
    needs_credit_s = (head_op_s == OP_READ) || (head_op_s == OP_SEARCH);
    credit_ok_s    = (SW'(rsp_count_r) + SW'(inflight_r)) < SW'(RSP_DEPTH);
    cmd_push_s     = cmd_valid_i & cmd_ready_r;
    if (state_r == ISSUE) begin
      cmd_pop_s = !needs_credit_s || credit_ok_s;
    end else begin
      cmd_pop_s = 1'b0;
    end
    issue_rs_s = cmd_pop_s & needs_credit_s;
    cap_s      = track_v_r[CAM_LAT-1];
    // The tracker tag alone decides which CAM port is sampled
    if (track_op_r[CAM_LAT-1]) begin
      cap_hit_s  = cam_search_valid_i;
      cap_data_s = {{(DATA_W-IDX_W){1'b0}}, cam_search_index_i};
    end else begin
      cap_hit_s  = cam_read_valid_i;
      cap_data_s = cam_read_value_i;
    end
    rsp_pop_s        = rsp_valid_r & rsp_ready_i;
    cmd_count_next_s = cmd_count_r + CCW'(cmd_push_s) - CCW'(cmd_pop_s);
    rsp_count_next_s = rsp_count_r + RCW'(cap_s) - RCW'(rsp_pop_s);
    inflight_next_s  = inflight_r + 3'(issue_rs_s) - 3'(cap_s);
  end

  // FIFO storage arrays (contents are qualified by the counts, so no reset)
  always_ff @(posedge clk) begin
    if (cmd_push_s) begin
      cmd_op_mem_r[cmd_wr_ptr_r]   <= cmd_op_i;
      cmd_idx_mem_r[cmd_wr_ptr_r]  <= cmd_index_i;
      cmd_data_mem_r[cmd_wr_ptr_r] <= cmd_data_i;
    end
    if (cap_s) begin
      rsp_op_mem_r[rsp_wr_ptr_r]   <= track_op_r[CAM_LAT-1];
      rsp_hit_mem_r[rsp_wr_ptr_r]  <= cap_hit_s;
      rsp_data_mem_r[rsp_wr_ptr_r] <= cap_data_s;
    end
  end

  // FIFO pointers, counts and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      cmd_wr_ptr_r <= '0;
      cmd_rd_ptr_r <= '0;
      cmd_count_r  <= '0;
      rsp_wr_ptr_r <= '0;
      rsp_rd_ptr_r <= '0;
      rsp_count_r  <= '0;
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (cmd_push_s) cmd_wr_ptr_r <= cmd_wr_ptr_r + CPW'(1'b1);
      if (cmd_pop_s)  cmd_rd_ptr_r <= cmd_rd_ptr_r + CPW'(1'b1);
      if (cap_s)      rsp_wr_ptr_r <= rsp_wr_ptr_r + RPW'(1'b1);
      if (rsp_pop_s)  rsp_rd_ptr_r <= rsp_rd_ptr_r + RPW'(1'b1);
      cmd_count_r <= cmd_count_next_s;
      rsp_count_r <= rsp_count_next_s;
      cmd_ready_r <= cmd_count_next_s < CCW'(CMD_DEPTH);
      rsp_valid_r <= rsp_count_next_s != '0;
      busy_r      <= (cmd_count_next_s != '0) || (inflight_next_s != '0);
    end
  end

  // In-flight tracker: one {valid, is_search} tag per CAM latency stage
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      track_v_r  <= '0;
      track_op_r <= '0;
      inflight_r <= '0;
    end else begin
      track_v_r[0]  <= issue_rs_s;
      track_op_r[0] <= head_op_s == OP_SEARCH;
      for (int i = 1; i < CAM_LAT; i++) begin
        track_v_r[i]  <= track_v_r[i-1];
        track_op_r[i] <= track_op_r[i-1];
      end
      inflight_r <= inflight_next_s;
    end
  end

  // Issue FSM with registered CAM port drive and illegal-op counter
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_r   <= IDLE;
      rd_en_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      sr_en_r   <= 1'b0;
      rd_idx_r  <= '0;
      wr_idx_r  <= '0;
      wr_data_r <= '0;
      sr_data_r <= '0;
      err_cnt_r <= 8'd0;
    end else begin
      rd_en_r <= 1'b0;
      wr_en_r <= 1'b0;
      sr_en_r <= 1'b0;
      case (state_r)
        IDLE: state_r <= cmd_push_s ? ISSUE : IDLE;
        ISSUE: begin
          if (cmd_pop_s) begin
            case (head_op_s)
              OP_READ: begin
                rd_en_r  <= 1'b1;
                rd_idx_r <= cmd_idx_mem_r[cmd_rd_ptr_r];
              end
              OP_WRITE: begin
                wr_en_r   <= 1'b1;
                wr_idx_r  <= cmd_idx_mem_r[cmd_rd_ptr_r];
                wr_data_r <= cmd_data_mem_r[cmd_rd_ptr_r];
              end
              OP_SEARCH: begin
                sr_en_r   <= 1'b1;
                sr_data_r <= cmd_data_mem_r[cmd_rd_ptr_r];
              end
              default: begin
                if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
              end
            endcase
            state_r <= (cmd_count_next_s == '0) ? IDLE : ISSUE;
          end else begin
            state_r <= HOLD;
          end
        end
        HOLD:    state_r <= credit_ok_s ? ISSUE : HOLD;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o         = cmd_ready_r;
  assign cam_read_enable_o   = rd_en_r;
  assign cam_read_index_o    = rd_idx_r;
  assign cam_write_enable_o  = wr_en_r;
  assign cam_write_index_o   = wr_idx_r;
  assign cam_write_data_o    = wr_data_r;
  assign cam_search_enable_o = sr_en_r;
  assign cam_search_data_o   = sr_data_r;
  assign rsp_valid_o         = rsp_valid_r;
  assign rsp_op_o            = rsp_op_mem_r[rsp_rd_ptr_r];
  assign rsp_hit_o           = rsp_hit_mem_r[rsp_rd_ptr_r];
  assign rsp_data_o          = rsp_data_mem_r[rsp_rd_ptr_r];
  assign busy_o              = busy_r;
  assign err_cnt_o           = err_cnt_r;

endmodule
